// File: rtl/icache_pkg.sv
// Shared types and defaults for the I-cache SRAM arbiter.
// Requester source codes and arbiter FSM states.
package icache_pkg;

  localparam int ICACHE_INDEX_W = 8;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_CPU  = 2'd1,
    SRC_PF   = 2'd2,
    SRC_LF   = 2'd3
  } arb_src_e;

  typedef enum logic {
    ARB_IDLE,
    ARB_SWEEP
  } arb_state_e;

endpackage

// File: rtl/icache_sram_arbiter_if.sv
// Request/RAM bundle between requesters and the I-cache SRAM arbiter.
// slave = arbiter side, master = requester / RAM / testbench side.
interface icache_sram_arbiter_if #(
  parameter int INDEX_W = 8,
  parameter int WAYS    = 2
);

  logic               inv_req;
  logic               inv_busy;
  logic               inv_done;

  logic               lf_valid;
  logic               lf_ready;
  logic [INDEX_W-1:0] lf_index;
  logic [WAYS-1:0]    lf_way;

  logic               cpu_valid;
  logic               cpu_ready;
  logic [INDEX_W-1:0] cpu_index;

  logic               pf_valid;
  logic               pf_ready;
  logic [INDEX_W-1:0] pf_index;

  logic               ram_cs;
  logic               ram_wen;
  logic [INDEX_W-1:0] ram_addr;
  logic [WAYS-1:0]    ram_way_we;
  logic               ram_vbit;

  logic               rd_resp_valid;
  logic [1:0]         rd_resp_src;
  logic               i_stall;

  modport slave (
    input  inv_req,
    output inv_busy, inv_done,
    input  lf_valid, lf_index, lf_way,
    output lf_ready,
    input  cpu_valid, cpu_index,
    output cpu_ready,
    input  pf_valid, pf_index,
    output pf_ready,
    output ram_cs, ram_wen, ram_addr,
    output ram_way_we, ram_vbit,
    output rd_resp_valid, rd_resp_src,
    output i_stall
  );

  modport master (
    output inv_req,
    input  inv_busy, inv_done,
    output lf_valid, lf_index, lf_way,
    input  lf_ready,
    output cpu_valid, cpu_index,
    input  cpu_ready,
    output pf_valid, pf_index,
    input  pf_ready,
    input  ram_cs, ram_wen, ram_addr,
    input  ram_way_we, ram_vbit,
    input  rd_resp_valid, rd_resp_src,
    input  i_stall
  );

endinterface

// File: rtl/icache_inv_sweeper.sv
// Full-cache invalidate sweep: walks every set once after inv_req.
// Ports: inv_req in; sweep_active/sweep_addr/inv_done out.
module icache_inv_sweeper
  import icache_pkg::*;
#(
  parameter int INDEX_W = ICACHE_INDEX_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inv_req,
  output logic               sweep_active,
  output logic [INDEX_W-1:0] sweep_addr,
  output logic               inv_done
);

  arb_state_e         state_q, state_d;
  logic [INDEX_W-1:0] cnt_q, cnt_d;
  logic               done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (inv_req) begin
          state_d = ARB_SWEEP;
          cnt_d   = '0;
        end
      end
      ARB_SWEEP: begin
        cnt_d = cnt_q + 1'b1;
        // Last set written: counter wraps, done pulses next cycle.
        if (&cnt_q) begin
          state_d = ARB_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign sweep_active = (state_q == ARB_SWEEP);
  assign sweep_addr   = cnt_q;
  assign inv_done     = done_q;

endmodule

// File: rtl/icache_sram_arbiter.sv
// I-cache tag/data SRAM arbiter: sweep > LF > CPU > PF, PF anti-starve.
// Ports: clk, rst_n, bus (slave); perf counters if ICACHE_ARB_PERF_CNT_EN.
module icache_sram_arbiter
  import icache_pkg::*;
#(
  parameter int INDEX_W       = ICACHE_INDEX_W,
  parameter int WAYS          = 2,
  parameter int PF_STARVE_MAX = 8
) (
  input  logic clk,
  input  logic rst_n,
  icache_sram_arbiter_if.slave bus
`ifdef ICACHE_ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_cpu_stall_cnt,
  output logic [31:0] perf_pf_grant_cnt
`endif
);

  localparam int SW = $clog2(PF_STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(PF_STARVE_MAX);

  logic               sweep_active;
  logic [INDEX_W-1:0] sweep_addr;
  logic               arb_free;
  logic               pf_pri;
  logic               lf_gnt, cpu_gnt, pf_gnt;

  logic [SW-1:0] starve_q, starve_d;
  logic          resp_valid_q, resp_valid_d;
  arb_src_e      resp_src_q, resp_src_d;

  icache_inv_sweeper #(
    .INDEX_W (INDEX_W)
  ) u_sweeper (
    .clk          (clk),
    .rst_n        (rst_n),
    .inv_req      (bus.inv_req),
    .sweep_active (sweep_active),
    .sweep_addr   (sweep_addr),
    .inv_done     (bus.inv_done)
  );

  // The inv_req cycle itself grants nothing.
  assign arb_free = !sweep_active && !bus.inv_req;
  assign pf_pri   = (starve_q == STARVE_MAX);

  always_comb begin
    lf_gnt  = 1'b0;
    cpu_gnt = 1'b0;
    pf_gnt  = 1'b0;
    if (arb_free) begin
      lf_gnt  = bus.lf_valid;
      cpu_gnt = !bus.lf_valid && bus.cpu_valid &&
                !(pf_pri && bus.pf_valid);
      pf_gnt  = !bus.lf_valid && bus.pf_valid &&
                (!bus.cpu_valid || pf_pri);
    end
  end

  always_comb begin
    bus.ram_cs     = 1'b0;
    bus.ram_wen    = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_way_we = '0;
    bus.ram_vbit   = 1'b0;
    unique case (1'b1)
      sweep_active: begin
        bus.ram_cs     = 1'b1;
        bus.ram_wen    = 1'b1;
        bus.ram_addr   = sweep_addr;
        bus.ram_way_we = '1;
      end
      lf_gnt: begin
        bus.ram_cs     = 1'b1;
        bus.ram_wen    = 1'b1;
        bus.ram_addr   = bus.lf_index;
        bus.ram_way_we = bus.lf_way;
        bus.ram_vbit   = 1'b1;
      end
      cpu_gnt: begin
        bus.ram_cs   = 1'b1;
        bus.ram_addr = bus.cpu_index;
      end
      pf_gnt: begin
        bus.ram_cs   = 1'b1;
        bus.ram_addr = bus.pf_index;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    if (pf_gnt || !bus.pf_valid) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + 1'b1;
    end
    resp_valid_d = cpu_gnt || pf_gnt;
    resp_src_d   = cpu_gnt ? SRC_CPU :
                   pf_gnt  ? SRC_PF  : SRC_NONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_src_q   <= SRC_NONE;
    end else begin
      starve_q     <= starve_d;
      resp_valid_q <= resp_valid_d;
      resp_src_q   <= resp_src_d;
    end
  end

  assign bus.lf_ready      = lf_gnt;
  assign bus.cpu_ready     = cpu_gnt;
  assign bus.pf_ready      = pf_gnt;
  assign bus.inv_busy      = sweep_active;
  assign bus.rd_resp_valid = resp_valid_q;
  assign bus.rd_resp_src   = resp_src_q;
  assign bus.i_stall       = bus.cpu_valid && !cpu_gnt;

`ifdef ICACHE_ARB_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] pfg_cnt_q, pfg_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    pfg_cnt_d   = pfg_cnt_q;
    if (bus.i_stall && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if (pf_gnt && !(&pfg_cnt_q)) begin
      pfg_cnt_d = pfg_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      pfg_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      pfg_cnt_q   <= pfg_cnt_d;
    end
  end

  assign perf_cpu_stall_cnt = stall_cnt_q;
  assign perf_pf_grant_cnt  = pfg_cnt_q;
`endif

endmodule

// File: tb/tb_icache_sram_arbiter.sv
// Directed bench for icache_sram_arbiter (INDEX_W=8, WAYS=2).
// Vector table for single-cycle grants, sequences for sweep/starve.
module tb_icache_sram_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  icache_sram_arbiter_if #(.INDEX_W(8), .WAYS(2)) bus ();

`ifdef ICACHE_ARB_PERF_CNT_EN
  logic [31:0] perf_cpu_stall_cnt;
  logic [31:0] perf_pf_grant_cnt;
`endif

  icache_sram_arbiter #(
    .INDEX_W       (8),
    .WAYS          (2),
    .PF_STARVE_MAX (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
`ifdef ICACHE_ARB_PERF_CNT_EN
    ,
    .perf_cpu_stall_cnt (perf_cpu_stall_cnt),
    .perf_pf_grant_cnt  (perf_pf_grant_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       lf_v;
    logic [7:0] lf_i;
    logic [1:0] lf_w;
    logic       cpu_v;
    logic [7:0] cpu_i;
    logic       pf_v;
    logic [7:0] pf_i;
    logic       e_lf_r;
    logic       e_cpu_r;
    logic       e_pf_r;
    logic       e_cs;
    logic       e_wen;
    logic [7:0] e_addr;
    logic [1:0] e_we;
    logic       e_vbit;
    logic       e_rv;
    logic [1:0] e_rs;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    bus.inv_req   = 1'b0;
    bus.lf_valid  = 1'b0;
    bus.lf_index  = '0;
    bus.lf_way    = '0;
    bus.cpu_valid = 1'b0;
    bus.cpu_index = '0;
    bus.pf_valid  = 1'b0;
    bus.pf_index  = '0;
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".ready"},
        {29'd0, bus.lf_ready, bus.cpu_ready, bus.pf_ready}, 32'd0);
    chk({nm, ".ram"},
        {19'd0, bus.ram_cs, bus.ram_wen, bus.ram_addr,
         bus.ram_way_we, bus.ram_vbit}, 32'd0);
    chk({nm, ".misc"},
        {27'd0, bus.rd_resp_valid, bus.rd_resp_src,
         bus.inv_busy, bus.inv_done}, 32'd0);
  endtask

  initial begin
    int bad;
    int done_seen;
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    idle_inputs();

    //               lf          cpu       pf        lr cr pr cs we addr  way v  rv rs
    vecs[0] = '{0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 0, 2'd0};
    vecs[1] = '{0, 8'h00, 2'b00, 1, 8'h2A, 0, 8'h00, 0, 1, 0, 1, 0, 8'h2A, 2'b00, 0, 1, 2'd1};
    vecs[2] = '{0, 8'h00, 2'b00, 0, 8'h00, 1, 8'h33, 0, 0, 1, 1, 0, 8'h33, 2'b00, 0, 1, 2'd2};
    vecs[3] = '{1, 8'h10, 2'b01, 0, 8'h00, 0, 8'h00, 1, 0, 0, 1, 1, 8'h10, 2'b01, 1, 0, 2'd0};
    vecs[4] = '{1, 8'h10, 2'b10, 1, 8'h20, 1, 8'h30, 1, 0, 0, 1, 1, 8'h10, 2'b10, 1, 0, 2'd0};
    vecs[5] = '{0, 8'h00, 2'b00, 1, 8'h20, 1, 8'h30, 0, 1, 0, 1, 0, 8'h20, 2'b00, 0, 1, 2'd1};
    vecs[6] = '{0, 8'h00, 2'b00, 0, 8'h00, 1, 8'h30, 0, 0, 1, 1, 0, 8'h30, 2'b00, 0, 1, 2'd2};
    vecs[7] = '{1, 8'hFF, 2'b11, 1, 8'h05, 0, 8'h00, 1, 0, 0, 1, 1, 8'hFF, 2'b11, 1, 0, 2'd0};
    vecs[8] = '{0, 8'h00, 2'b00, 0, 8'h00, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 2'b00, 0, 0, 2'd0};

    // Reset held, then released with no requests.
    #2;
    chk_all_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk_all_zero("rst_idle");
    end

    // Table-driven single-cycle grants.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bus.lf_valid  = vecs[i].lf_v;
      bus.lf_index  = vecs[i].lf_i;
      bus.lf_way    = vecs[i].lf_w;
      bus.cpu_valid = vecs[i].cpu_v;
      bus.cpu_index = vecs[i].cpu_i;
      bus.pf_valid  = vecs[i].pf_v;
      bus.pf_index  = vecs[i].pf_i;
      #1;
      chk($sformatf("v%0d.ready", i),
          {29'd0, bus.lf_ready, bus.cpu_ready, bus.pf_ready},
          {29'd0, vecs[i].e_lf_r, vecs[i].e_cpu_r, vecs[i].e_pf_r});
      chk($sformatf("v%0d.ram", i),
          {19'd0, bus.ram_cs, bus.ram_wen, bus.ram_addr,
           bus.ram_way_we, bus.ram_vbit},
          {19'd0, vecs[i].e_cs, vecs[i].e_wen, vecs[i].e_addr,
           vecs[i].e_we, vecs[i].e_vbit});
      chk($sformatf("v%0d.stall", i), {31'd0, bus.i_stall},
          {31'd0, vecs[i].cpu_v & ~vecs[i].e_cpu_r});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.resp", i),
          {29'd0, bus.rd_resp_valid, bus.rd_resp_src},
          {29'd0, vecs[i].e_rv, vecs[i].e_rs});
    end

    // PF starvation: 8 blocked cycles, then PF promoted over CPU.
    @(negedge clk);
    idle_inputs();
    bus.cpu_valid = 1'b1;
    bus.cpu_index = 8'h44;
    bus.pf_valid  = 1'b1;
    bus.pf_index  = 8'h55;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk($sformatf("starve%0d", c),
          {30'd0, bus.cpu_ready, bus.pf_ready}, 32'd2);
      @(negedge clk);
    end
    #1;
    chk("starve.promote",
        {29'd0, bus.cpu_ready, bus.pf_ready, bus.i_stall}, 32'd3);
    chk("starve.addr", {24'd0, bus.ram_addr}, 32'h55);
    @(negedge clk);
    bus.pf_valid = 1'b0;
    #1;
    chk("starve.after", {31'd0, bus.cpu_ready}, 32'd1);

    // Full sweep with CPU waiting.
    @(negedge clk);
    idle_inputs();
    bus.inv_req   = 1'b1;
    bus.cpu_valid = 1'b1;
    bus.cpu_index = 8'h66;
    #1;
    chk("inv_req.cycle",
        {29'd0, bus.cpu_ready, bus.ram_cs, bus.i_stall}, 32'd1);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      bus.inv_req = 1'b0;
      #1;
      if (bus.ram_cs !== 1'b1 || bus.ram_wen !== 1'b1 ||
          bus.ram_addr !== 8'(k) || bus.ram_way_we !== 2'b11 ||
          bus.ram_vbit !== 1'b0 || bus.cpu_ready !== 1'b0 ||
          bus.inv_busy !== 1'b1 || bus.inv_done !== 1'b0) begin
        bad++;
      end
    end
    chk("sweep.writes", bad, 0);
    @(negedge clk);
    #1;
    chk("sweep.done",
        {29'd0, bus.inv_done, bus.inv_busy, bus.cpu_ready}, 32'd5);
    @(negedge clk);
    #1;
    chk("sweep.done_pulse",
        {30'd0, bus.inv_done, bus.cpu_ready}, 32'd1);

    // Reset during sweep write 100 aborts the sweep.
    @(negedge clk);
    idle_inputs();
    bus.inv_req = 1'b1;
    @(negedge clk);
    bus.inv_req = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    chk("abort.addr100", {23'd0, bus.inv_busy, bus.ram_addr}, 32'h164);
    rst_n = 1'b0;
    #1;
    chk("abort.rst",
        {30'd0, bus.inv_busy, bus.ram_cs}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      #1;
      if (bus.inv_done !== 1'b0 || bus.inv_busy !== 1'b0) done_seen++;
    end
    chk("abort.no_done", done_seen, 0);
    @(negedge clk);
    bus.inv_req = 1'b1;
    @(negedge clk);
    bus.inv_req = 1'b0;
    #1;
    chk("restart.addr0",
        {22'd0, bus.inv_busy, bus.ram_cs, bus.ram_addr}, 32'h300);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
